// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: loader FSM states, loader error causes and the
// processor status encoding used by the SEQ top.
package y86_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALTED = 3'd4,
    ST_ERR    = 3'd5
  } ld_state_e;

  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_CPU  = 2'd3;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

endpackage

// File: rtl/imem_loader_if.sv
// Program byte stream: valid/ready handshake plus last-byte flag and the
// expected checksum that accompanies the final byte.
interface imem_loader_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic [7:0] exp_csum;

  modport master (output in_valid, in_data, in_last, exp_csum, input in_ready);
  modport slave  (input in_valid, in_data, in_last, exp_csum, output in_ready);
endinterface

// File: rtl/imem_loader_csum.sv
// Modulo-256 running sum of program bytes with clear, accumulate-enable and
// an equality compare against a reference checksum.
module load_csum (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  input  logic [7:0] cmp_val,
  output logic       match
);
  logic [7:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr)     acc_d = 8'd0;
    else if (en) acc_d = acc_q + din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) acc_q <= 8'd0;
    else        acc_q <= acc_d;
  end

  assign match = (acc_q == cmp_val);
endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams a program into instruction memory from address 0,
// verifies its checksum, then releases the CPU and tracks halt/fault status.
module imem_loader
  import y86_pkg::*;
#(
  parameter int IMEM_DEPTH = 1024,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  imem_loader_if.slave      s,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_run,
  input  logic              cpu_hlt,
  input  logic              cpu_err,
  output logic [ADDR_W:0]   prog_len,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(IMEM_DEPTH - 1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d, len_q, len_d;
  logic [7:0]        exp_q, exp_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d, run_q, run_d, done_q, done_d, err_q, err_d;
  logic [1:0]        code_q, code_d;
  logic              hs, csum_clr, csum_en, csum_ok;

  assign s.in_ready = (state_q == ST_LOAD);
  assign hs         = s.in_valid & s.in_ready;

  load_csum u_csum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (csum_clr),
    .en      (csum_en),
    .din     (s.in_data),
    .cmp_val (exp_q),
    .match   (csum_ok)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    exp_d    = exp_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    run_d    = run_q;
    done_d   = done_q;
    err_d    = err_q;
    code_d   = code_q;
    csum_clr = 1'b0;
    csum_en  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_HALTED, ST_ERR: begin
        if (start) begin
          state_d  = ST_LOAD;
          cnt_d    = '0;
          csum_clr = 1'b1;
          run_d    = 1'b0;
          done_d   = 1'b0;
          err_d    = 1'b0;
          code_d   = 2'd0;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = s.in_data;
          cnt_d   = cnt_q + 1'b1;
          csum_en = 1'b1;
          if (s.in_last) begin
            exp_d   = s.exp_csum;
            state_d = ST_CHECK;
          end else if (cnt_q == LAST_ADDR) begin
            // Memory is full and more bytes are coming: refuse rather than wrap.
            state_d = ST_ERR;
            err_d   = 1'b1;
            code_d  = ERR_OVF;
          end
        end
      end
      ST_CHECK: begin
        len_d = cnt_q;
        if (csum_ok) begin
          state_d = ST_RUN;
          run_d   = 1'b1;
        end else begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          code_d  = ERR_CSUM;
        end
      end
      ST_RUN: begin
        // A fault outranks a simultaneous halt.
        if (cpu_err) begin
          state_d = ST_ERR;
          run_d   = 1'b0;
          err_d   = 1'b1;
          code_d  = ERR_CPU;
        end else if (cpu_hlt) begin
          state_d = ST_HALTED;
          run_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      exp_q   <= 8'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 8'd0;
      run_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      run_q   <= run_d;
      done_q  <= done_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_run    = run_q;
  assign prog_len   = len_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = code_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader built with a 16-byte instruction memory.
module tb_imem_loader;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, cpu_hlt, cpu_err;
  logic          imem_we, cpu_run, done, err;
  logic [AW-1:0] imem_addr;
  logic [7:0]    imem_wdata;
  logic [AW:0]   prog_len;
  logic [1:0]    err_code;
  int            checks = 0;
  int            errors = 0;

  imem_loader_if sif ();

  imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s(sif.slave),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .cpu_hlt(cpu_hlt), .cpu_err(cpu_err),
    .prog_len(prog_len), .done(done), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic [7:0] cs);
    sif.in_valid = 1'b1; sif.in_data = d; sif.in_last = last; sif.exp_csum = cs;
    tick();
    sif.in_valid = 1'b0; sif.in_last = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [7:0] prog1 [4] = '{8'h30, 8'h00, 8'h10, 8'h00};
  logic [7:0] rdat [8];
  logic [7:0] rsum;
  int         sent, expw, cyc;
  logic       v;

  initial begin
    rst_n = 1'b0; start = 1'b0; cpu_hlt = 1'b0; cpu_err = 1'b0;
    sif.in_valid = 1'b0; sif.in_data = 8'h00; sif.in_last = 1'b0; sif.exp_csum = 8'h00;
    tick(); tick();
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_run", cpu_run, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_ready", sif.in_ready, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", sif.in_ready, 0);

    // Good 4-byte program, sum 0x40
    pulse_start();
    chk("t1_ready", sif.in_ready, 1);
    chk("t1_we_idle", imem_we, 0);
    for (int i = 0; i < 4; i++) begin
      send(prog1[i], i == 3, 8'h40);
      chk("t1_we", imem_we, 1);
      chk("t1_addr", imem_addr, i);
      chk("t1_wdata", imem_wdata, prog1[i]);
    end
    chk("t1_check_run", cpu_run, 0);
    chk("t1_check_ready", sif.in_ready, 0);
    tick();
    chk("t1_run", cpu_run, 1);
    chk("t1_len", prog_len, 4);
    chk("t1_we_off", imem_we, 0);

    // Halt, then reload a single byte
    cpu_hlt = 1'b1; tick(); cpu_hlt = 1'b0;
    chk("t3_run", cpu_run, 0);
    chk("t3_done", done, 1);
    chk("t3_err", err, 0);
    pulse_start();
    chk("t3_done_clr", done, 0);
    send(8'h00, 1'b1, 8'h00);
    chk("t3_we", imem_we, 1);
    chk("t3_addr", imem_addr, 0);
    chk("t3_wdata", imem_wdata, 8'h00);
    tick(); tick();
    chk("t3_run2", cpu_run, 1);
    chk("t3_len", prog_len, 1);

    // Halt and fault together: fault wins
    cpu_hlt = 1'b1; cpu_err = 1'b1; tick(); cpu_hlt = 1'b0; cpu_err = 1'b0;
    chk("t6_err", err, 1);
    chk("t6_code", err_code, 3);
    chk("t6_done", done, 0);
    chk("t6_run", cpu_run, 0);

    // Checksum mismatch
    pulse_start();
    chk("t2_err_clr", err, 0);
    chk("t2_code_clr", err_code, 0);
    for (int i = 0; i < 4; i++) send(prog1[i], i == 3, 8'h41);
    chk("t2_check_run", cpu_run, 0);
    tick();
    chk("t2_err", err, 1);
    chk("t2_code", err_code, 2);
    chk("t2_run", cpu_run, 0);
    tick();
    chk("t2_run_later", cpu_run, 0);

    // Overflow: 16 bytes without last
    pulse_start();
    for (int i = 0; i < DEPTH; i++) begin
      send(8'(i + 1), 1'b0, 8'h00);
      chk("t4_addr", imem_addr, i);
      chk("t4_wdata", imem_wdata, i + 1);
    end
    chk("t4_err", err, 1);
    chk("t4_code", err_code, 1);
    sif.in_valid = 1'b1; sif.in_data = 8'hEE;
    chk("t4_ready17", sif.in_ready, 0);
    tick();
    sif.in_valid = 1'b0;
    chk("t4_we17", imem_we, 0);
    chk("t4_code_hold", err_code, 1);

    // Exactly full program, sum 0..15 = 0x78
    pulse_start();
    for (int i = 0; i < DEPTH; i++) send(8'(i), i == DEPTH - 1, 8'h78);
    chk("t4b_addr", imem_addr, 15);
    chk("t4b_err", err, 0);
    tick();
    chk("t4b_run", cpu_run, 1);
    chk("t4b_len", prog_len, 16);
    cpu_hlt = 1'b1; tick(); cpu_hlt = 1'b0;
    chk("t4b_done", done, 1);

    // Reset in the middle of a load
    pulse_start();
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i), 1'b0, 8'h00);
    rst_n = 1'b0; sif.in_valid = 1'b1; sif.in_data = 8'h55;
    tick();
    rst_n = 1'b1; sif.in_valid = 1'b0;
    chk("t5_we", imem_we, 0);
    chk("t5_addr", imem_addr, 0);
    chk("t5_wdata", imem_wdata, 0);
    chk("t5_ready", sif.in_ready, 0);
    chk("t5_len", prog_len, 0);
    chk("t5_flags", {cpu_run, done, err, err_code}, 0);
    pulse_start();
    send(8'hAB, 1'b1, 8'hAB);
    chk("t5_we2", imem_we, 1);
    chk("t5_addr2", imem_addr, 0);
    chk("t5_wdata2", imem_wdata, 8'hAB);
    tick(); tick();
    chk("t5_run", cpu_run, 1);
    cpu_hlt = 1'b1; tick(); cpu_hlt = 1'b0;

    // Random valid gaps: writes must be in order with no gaps or repeats
    rsum = 8'h00;
    for (int k = 0; k < 8; k++) begin
      rdat[k] = 8'(k * 7 + 3);
      rsum    = rsum + rdat[k];
    end
    pulse_start();
    sent = 0; expw = 0; cyc = 0;
    while (sent < 8 && cyc < 200) begin
      v = 1'($urandom_range(0, 1));
      sif.in_valid = v; sif.in_data = rdat[sent]; sif.in_last = (sent == 7); sif.exp_csum = rsum;
      tick();
      cyc++;
      chk("t6r_we", imem_we, v);
      if (v) begin
        chk("t6r_addr", imem_addr, expw);
        chk("t6r_wdata", imem_wdata, rdat[expw]);
        expw++;
        sent++;
      end
    end
    sif.in_valid = 1'b0; sif.in_last = 1'b0;
    chk("t6r_bytes_sent", sent, 8);
    tick();
    chk("t6r_run", cpu_run, 1);
    chk("t6r_len", prog_len, 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader sitting directly upstream of the SEQ fetch stage.
- Accepts a Y86-64 program as a byte stream over a valid/ready handshake and writes it byte-by-byte into instruction memory starting at address 0.
- Checks a modulo-256 checksum, then releases the processor via `cpu_run` and tracks its halt/error status.
- Allows the program to be reloaded after a halt or an error.

Parameters:
- `IMEM_DEPTH`, 1024, number of instruction-memory bytes; must be a power of 2.
- `ADDR_W`, 10, equal to log2(`IMEM_DEPTH`).

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous reset, active-low.
- `start` input 1: one-cycle pulse that begins a load (only accepted in IDLE, HALTED and ERR).
- `in_valid` input 1: stream byte valid.
- `in_ready` output 1: loader can accept a byte.
- `in_data` input 8: program byte.
- `in_last` input 1: the current byte is the final program byte.
- `exp_csum` input 8: expected checksum; sampled on the `in_last` handshake.
- `imem_we` output 1: instruction-memory byte write enable.
- `imem_addr` output `ADDR_W`: write address.
- `imem_wdata` output 8: write data.
- `cpu_run` output 1: processor enable; the processor holds PC at 0 while this is low.
- `cpu_hlt` input 1: processor reached HLT (stat_HLT).
- `cpu_err` input 1: processor reached stat_ADR or stat_INS.
- `prog_len` output `ADDR_W`+1: number of bytes loaded.
- `done` output 1: program ran to HLT.
- `err` output 1: error latched.
- `err_code` output 2: error cause; 1 = overflow, 2 = checksum mismatch, 3 = CPU fault.

Behaviour:
- Reset (`rst_n`=0 at an edge):
  - State goes to IDLE.
  - All outputs read 0; `byte_cnt`, the checksum accumulator and `prog_len` clear to 0.
  - Reset wins over every other input, including mid-load and mid-run.
  - Memory contents are not cleared.
- States: IDLE, LOAD, CHECK, RUN, HALTED, ERR. State is encoded in a 3-bit register.
- IDLE:
  - `in_ready`=0.
  - `start`=1 goes to LOAD, clearing `byte_cnt`, the accumulator, `done`, `err` and `err_code`.
- LOAD:
  - `in_ready`=1, driven combinationally from the state.
  - A handshake is `in_valid` & `in_ready`. On a handshake, register `imem_we`=1, `imem_addr`=`byte_cnt`[`ADDR_W`-1:0] and `imem_wdata`=`in_data`; the write appears 1 cycle after the handshake.
  - On a handshake, update `byte_cnt`+=1 and accumulator = (acc + `in_data`) mod 256.
  - `imem_we`=0 in every cycle without a handshake.
  - `start` is ignored while in LOAD.
- LOAD exits:
  - Handshake with `in_last`=1: latch `exp_csum` and go to CHECK. The final byte is still written.
  - Handshake at `byte_cnt`=`IMEM_DEPTH`-1 with `in_last`=0: the byte is written, then go to ERR with `err_code`=1 (overflow).
  - A final byte at exactly address `IMEM_DEPTH`-1 with `in_last`=1 is legal and goes to CHECK.
  - Address never wraps.
- CHECK (exactly 1 cycle):
  - `in_ready`=0.
  - `prog_len`=`byte_cnt`.
  - Accumulator equal to the latched checksum: go to RUN. Otherwise go to ERR with `err_code`=2.
- RUN:
  - `cpu_run`=1, registered; it rises the cycle after CHECK.
  - `cpu_err`=1 goes to ERR with `err_code`=3.
  - `cpu_hlt`=1 goes to HALTED.
  - If both are high in the same cycle, `cpu_err` wins.
  - Both inputs are ignored outside RUN.
- HALTED:
  - `cpu_run`=0, `done`=1.
  - `start` goes to LOAD.
- ERR:
  - `cpu_run`=0, `err`=1, `err_code` held.
  - `start` goes to LOAD, which clears `err` and `err_code`.
- Bit widths:
  - `byte_cnt` is `ADDR_W`+1 bits, so `prog_len` can represent `IMEM_DEPTH`.
  - The checksum is 8-bit and wraps.
- An empty program is impossible: `in_last` always accompanies a real byte.

Decomposition:
- Shared package `y86_pkg` holds:
  - The state enum localparams (IDLE=0 … ERR=5).
  - `ERR_OVF`=1, `ERR_CSUM`=2, `ERR_CPU`=3.
  - The stat encoding shared with the SEQ top (AOK/HLT/ADR/INS).
- One natural sub-module, `load_csum`: the 8-bit running-sum accumulator with clear, accumulate-enable and a compare output.
- The FSM, counter and write-port registers stay in `imem_loader`.

Test Plan:
1. Stream 30 00 10 00 (`in_last` on the 4th byte), `exp_csum`=0x40, `in_valid` held high:
   - writes to addresses 0–3 with data 30, 00, 10, 00, each 1 cycle after its handshake;
   - `prog_len`=4;
   - `cpu_run` rises 2 cycles after the last handshake.
2. Same stream with `exp_csum`=0x41: `err`=1, `err_code`=2, `cpu_run` never rises.
3. In RUN, pulse `cpu_hlt`: next cycle `cpu_run`=0 and `done`=1. Then pulse `start`, reload 1 byte 00 with `exp_csum`=00: `done` clears and the byte is written at address 0.
4. With `IMEM_DEPTH`=16:
   - 16 bytes without `in_last`: address 15 is written, then `err_code`=1, and the 17th byte sees `in_ready`=0.
   - 16 bytes with `in_last` on the 16th: run starts and `prog_len`=16.
5. Assert `rst_n`=0 mid-LOAD after 3 bytes: next cycle state is IDLE, all outputs 0; a following `start` plus 1-byte load writes at address 0.
6. In RUN, assert `cpu_hlt` and `cpu_err` in the same cycle: `err_code`=3, `done`=0. Toggle `in_valid` randomly during LOAD: bytes are written strictly in order with no gaps or duplicates.
